// File: rtl/ext_fifo_rx.sv
// Receive-side external FIFO: buffers the MAC's push-style byte stream and replays it as AXI-Stream.
// The MAC cannot be stalled, so overflowing frames are dropped or closed early as truncated and bad.
module ext_fifo_rx #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       wr_i,
  input  logic       sop_i,
  input  logic       eop_i,
  input  logic       err_i,
  input  logic       flush_i,
  output logic       overflow_o,
  output logic [7:0] axis_tdata_o,
  output logic       axis_tvalid_o,
  output logic       axis_tlast_o,
  output logic       axis_tuser_o,
  input  logic       axis_tready_i,
  output logic [15:0] frames_o,
  output logic [15:0] drops_o
);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH - 1);

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  state_t        state, state_nxt;

  logic       full, pop, push;
  logic [9:0] push_word;
  logic       ovf_set, good_inc, drop_inc;
  logic [9:0] head;

  // The top slot is held back so a frame cut short by overflow can still be closed with tlast.
  assign full = (count >= FULL_LVL);
  assign pop  = axis_tvalid_o & axis_tready_i;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    push      = 1'b0;
    push_word = {2'b00, data_i};
    ovf_set   = 1'b0;
    good_inc  = 1'b0;
    drop_inc  = 1'b0;
    state_nxt = state;
    if (wr_i) begin
      unique case (state)
        IDLE: begin
          if (sop_i) begin
            if (!full) begin
              push      = 1'b1;
              push_word = {err_i & eop_i, eop_i, data_i};
              if (eop_i) begin
                good_inc = ~err_i;
                drop_inc = err_i;
              end else begin
                state_nxt = RECV;
              end
            end else begin
              ovf_set   = 1'b1;
              drop_inc  = 1'b1;
              state_nxt = eop_i ? IDLE : DROP;
            end
          end
        end
        RECV: begin
          push = 1'b1;
          if (eop_i) begin
            push_word = {err_i, 1'b1, data_i};
            good_inc  = ~err_i;
            drop_inc  = err_i;
            state_nxt = IDLE;
          end else if (full) begin
            push_word = {2'b11, data_i};
            ovf_set   = 1'b1;
            drop_inc  = 1'b1;
            state_nxt = DROP;
          end else if (sop_i) begin
            // A new SOP without EOP: close the old frame as bad and skip the new one.
            push_word = {2'b11, data_i};
            drop_inc  = 1'b1;
            state_nxt = DROP;
          end
        end
        DROP: begin
          if (eop_i) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= IDLE;
      overflow_o <= 1'b0;
      frames_o   <= '0;
      drops_o    <= '0;
    end else if (flush_i) begin
      rd_ptr     <= wr_ptr;
      count      <= '0;
      state      <= IDLE;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      state      <= state_nxt;
      overflow_o <= ovf_set;
      if (good_inc && frames_o != 16'hFFFF) frames_o <= frames_o + 1'b1;
      if (drop_inc && drops_o  != 16'hFFFF) drops_o  <= drops_o + 1'b1;
    end
  end

  assign axis_tvalid_o = (count != '0);
  assign head          = axis_tvalid_o ? mem[rd_ptr] : '0;
  assign axis_tdata_o  = head[7:0];
  assign axis_tlast_o  = head[8];
  assign axis_tuser_o  = head[9];

endmodule

// File: tb/tb_ext_fifo_rx.sv
// Directed bench for ext_fifo_rx: stimulus pushes expected beats into a scoreboard queue,
// a monitor pops and compares every accepted AXIS beat.
module tb_ext_fifo_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        wr, sop, eop, err, flush;
  logic        overflow;
  logic [7:0]  tdata;
  logic        tvalid, tlast, tuser;
  logic        tready;
  logic [15:0] frames, drops;

  logic tready_man = 1'b0;
  logic tog_en     = 1'b0;
  logic tog        = 1'b0;
  assign tready = tog_en ? tog : tready_man;

  int n_vec   = 0;
  int n_fail  = 0;
  int ovf_cnt = 0;
  logic [9:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;

  ext_fifo_rx #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .data_i(data), .wr_i(wr), .sop_i(sop), .eop_i(eop),
    .err_i(err), .flush_i(flush), .overflow_o(overflow),
    .axis_tdata_o(tdata), .axis_tvalid_o(tvalid), .axis_tlast_o(tlast),
    .axis_tuser_o(tuser), .axis_tready_i(tready),
    .frames_o(frames), .drops_o(drops)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void exp_beat(input logic user, input logic last, input logic [7:0] d);
    sb.push_back({user, last, d});
  endfunction

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && tvalid && tready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL beat_unexpected: got 0x%0h, expected no beat", {tuser, tlast, tdata});
      end else begin
        check("beat", {22'd0, tuser, tlast, tdata}, {22'd0, sb.pop_front()});
      end
    end
    if (!rst && overflow) ovf_cnt++;
  end

  task automatic mac(input logic [7:0] d, input logic s, input logic e, input logic r);
    wr = 1'b1; data = d; sop = s; eop = e; err = r;
    @(posedge clk); #1;
    wr = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0;
  endtask

  task automatic frame(input logic [7:0] base, input int len, input logic bad, input bit gap);
    for (int i = 0; i < len; i++) begin
      mac(base + 8'(i), i == 0, i == len - 1, bad && (i == len - 1));
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    tready_man = 1'b1;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    check({name, "_sb_empty"}, sb.size(), 0);
    check({name, "_tvalid_low"}, {31'd0, tvalid}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr = 1'b0; data = '0; sop = 1'b0; eop = 1'b0; err = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_tvalid", {31'd0, tvalid}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    check("rst_frames", {16'd0, frames}, 0);
    check("rst_drops", {16'd0, drops}, 0);
    @(posedge clk); #1;

    // Plain 6-byte frame streamed straight through.
    tready_man = 1'b1;
    for (int i = 0; i < 6; i++) exp_beat(1'b0, i == 5, 8'h10 + 8'(i));
    frame(8'h10, 6, 1'b0, 1'b0);
    drain("basic");
    check("basic_frames", {16'd0, frames}, 1);
    check("basic_ovf", ovf_cnt, 0);

    // 20-byte frame into a stalled FIFO: bytes 0..14 fill to 15, byte 15 closes it in the spare slot.
    tready_man = 1'b0;
    for (int i = 0; i < 15; i++) exp_beat(1'b0, 1'b0, 8'h20 + 8'(i));
    exp_beat(1'b1, 1'b1, 8'h2F);
    frame(8'h20, 20, 1'b0, 1'b0);
    check("trunc_drops", {16'd0, drops}, 1);
    check("trunc_frames", {16'd0, frames}, 1);
    check("trunc_ovf", ovf_cnt, 1);
    drain("trunc");

    // 15 stored bytes, then a SOP arrives while full: whole frame dropped.
    tready_man = 1'b0;
    for (int i = 0; i < 15; i++) exp_beat(1'b0, i == 14, 8'h40 + 8'(i));
    frame(8'h40, 15, 1'b0, 1'b0);
    frame(8'h50, 4, 1'b0, 1'b0);
    check("full_sop_ovf", ovf_cnt, 2);
    check("full_sop_drops", {16'd0, drops}, 2);
    drain("full_sop");
    exp_beat(1'b0, 1'b0, 8'h60);
    exp_beat(1'b0, 1'b0, 8'h61);
    exp_beat(1'b0, 1'b1, 8'h62);
    frame(8'h60, 3, 1'b0, 1'b0);
    drain("after_drop");
    check("after_drop_frames", {16'd0, frames}, 3);

    // Bad frame: error flagged with eop.
    for (int i = 0; i < 4; i++) exp_beat(i == 3, i == 3, 8'h70 + 8'(i));
    frame(8'h70, 4, 1'b1, 1'b0);
    drain("err");
    check("err_frames", {16'd0, frames}, 3);
    check("err_drops", {16'd0, drops}, 3);

    // Missing EOP: the new SOP byte closes the old frame as bad, its frame is skipped.
    exp_beat(1'b0, 1'b0, 8'h80);
    exp_beat(1'b0, 1'b0, 8'h81);
    exp_beat(1'b0, 1'b0, 8'h82);
    exp_beat(1'b1, 1'b1, 8'h90);
    mac(8'h80, 1'b1, 1'b0, 1'b0);
    mac(8'h81, 1'b0, 1'b0, 1'b0);
    mac(8'h82, 1'b0, 1'b0, 1'b0);
    mac(8'h90, 1'b1, 1'b0, 1'b0);
    mac(8'h91, 1'b0, 1'b0, 1'b0);
    mac(8'h92, 1'b0, 1'b1, 1'b0);
    exp_beat(1'b0, 1'b0, 8'hA0);
    exp_beat(1'b0, 1'b1, 8'hA1);
    frame(8'hA0, 2, 1'b0, 1'b0);
    drain("noeop");
    check("noeop_frames", {16'd0, frames}, 4);
    check("noeop_drops", {16'd0, drops}, 4);
    check("noeop_ovf", ovf_cnt, 2);

    // Three 64-byte frames at half rate with tready toggling every cycle.
    tready_man = 1'b0;
    tog_en = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 64; i++) exp_beat(1'b0, i == 63, 8'(f * 64 + i));
    for (int f = 0; f < 3; f++) frame(8'(f * 64), 64, 1'b0, 1'b1);
    tog_en = 1'b0;
    drain("stream");
    check("stream_frames", {16'd0, frames}, 7);
    check("stream_drops", {16'd0, drops}, 4);
    check("stream_ovf", ovf_cnt, 2);

    // Flush with data pending; a write in the flush cycle is discarded.
    tready_man = 1'b0;
    frame(8'hB0, 3, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_flush_tvalid", {31'd0, tvalid}, 1);
    @(posedge clk); #1;
    flush = 1'b1;
    wr = 1'b1; data = 8'hEE; sop = 1'b1; eop = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; wr = 1'b0; sop = 1'b0; eop = 1'b0;
    @(negedge clk);
    check("flush_tvalid", {31'd0, tvalid}, 0);
    check("flush_frames", {16'd0, frames}, 8);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("flush_write_dropped", {31'd0, tvalid}, 0);
    @(posedge clk); #1;
    tready_man = 1'b1;
    exp_beat(1'b0, 1'b1, 8'hC0);
    mac(8'hC0, 1'b1, 1'b1, 1'b0);
    drain("post_flush");
    check("post_flush_frames", {16'd0, frames}, 9);
    check("final_ovf", ovf_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
